led_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the multi-digit LED/7-segment display.

---
 rtl/led_scan_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_led_scan_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: time-multiplexed LED/7-segment scan controller.
// One digit per slot, each slot opening with an anti-ghost blanking window.
// A valid/ready port fills a shadow buffer that is committed at frame wraps.
module led_scan_ctrl #(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned SLOT_CYCLES    = 100000,
  parameter int unsigned BLANK_CYCLES   = 1000,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = $clog2(SLOT_CYCLES);
  localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'((BLANK_CYCLES == 0) ? 32'd0 : BLANK_CYCLES - 32'd1);
  localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 32'd1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  // A slot with no blanking window starts directly in DRIVE.
  localparam state_t SLOT_START = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

  state_t                         state, state_nxt;
  logic [CNT_W-1:0]               slot_cnt, slot_nxt;
  logic [DIG_W-1:0]               digit, digit_nxt;
  logic                           wrap_c;
  logic [NUM_DIGITS-1:0][3:0]     act_nib, shd_nib;
  logic [NUM_DIGITS-1:0]          act_dp, shd_dp;
  logic                           pending;
  logic                           accept_c, commit_c, pending_nxt_c;
  logic [NUM_DIGITS-1:0]          an_c;
  logic [6:0]                     seg_c;
  logic                           dp_c;

  // Hex nibble to active-high {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'b0111111;
      4'h1: seg_decode = 7'b0000110;
      4'h2: seg_decode = 7'b1011011;
      4'h3: seg_decode = 7'b1001111;
      4'h4: seg_decode = 7'b1100110;
      4'h5: seg_decode = 7'b1101101;
      4'h6: seg_decode = 7'b1111101;
      4'h7: seg_decode = 7'b0000111;
      4'h8: seg_decode = 7'b1111111;
      4'h9: seg_decode = 7'b1101111;
      4'hA: seg_decode = 7'b1110111;
      4'hB: seg_decode = 7'b1111100;
      4'hC: seg_decode = 7'b0111001;
      4'hD: seg_decode = 7'b1011110;
      4'hE: seg_decode = 7'b1111001;
      default: seg_decode = 7'b1110001;
    endcase
  endfunction

  // Scan state, slot counter and digit index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      slot_cnt <= '0;
      digit    <= '0;
    end else begin
      state    <= state_nxt;
      slot_cnt <= slot_nxt;
      digit    <= digit_nxt;
    end
  end

  // Next-state logic; disabling the scan overrides every state.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot_cnt;
    digit_nxt = digit;
    wrap_c    = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      slot_nxt  = '0;
      digit_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SLOT_START;
          slot_nxt  = '0;
          digit_nxt = '0;
        end
        BLANK: begin
          slot_nxt = slot_cnt + CNT_W'(1);
          if (slot_cnt == BLANK_LAST) state_nxt = DRIVE;
        end
        DRIVE: begin
          if (slot_cnt == SLOT_LAST) begin
            slot_nxt  = '0;
            state_nxt = SLOT_START;
            if (digit == DIG_LAST) begin
              digit_nxt = '0;
              wrap_c    = 1'b1;
            end else begin
              digit_nxt = digit + DIG_W'(1);
            end
          end else begin
            slot_nxt = slot_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          slot_nxt  = '0;
          digit_nxt = '0;
        end
      endcase
    end
  end

  // Display drive from the current state, before the output register.
  always_comb begin
    logic [NUM_DIGITS-1:0] onehot;
    logic [6:0]            pattern;
    logic                  dp_on;
    onehot  = '0;
    pattern = '0;
    dp_on   = 1'b0;
    if (state == DRIVE) begin
      for (int i = 0; i < NUM_DIGITS; i++) onehot[i] = (DIG_W'(i) == digit);
      pattern = seg_decode(act_nib[digit]);
      dp_on   = act_dp[digit];
    end
    an_c  = onehot ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
    seg_c = pattern ^ {7{SEG_ACTIVE_LOW}};
    dp_c  = dp_on ^ SEG_ACTIVE_LOW;
  end

  // Handshake: accept only when no commit is outstanding; commit at a frame
  // wrap, or right away while idle.
  always_comb begin
    accept_c      = wr_valid & wr_ready;
    commit_c      = pending & ((state == IDLE) | wrap_c);
    pending_nxt_c = accept_c | (pending & ~commit_c);
  end

  // Shadow/active buffers, pending flag and ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shd_nib  <= '0;
      shd_dp   <= '0;
      act_nib  <= '0;
      act_dp   <= '0;
      pending  <= 1'b0;
      wr_ready <= 1'b0;
    end else begin
      if (accept_c) begin
        shd_nib <= wr_data;
        shd_dp  <= wr_dp;
      end
      if (commit_c) begin
        act_nib <= shd_nib;
        act_dp  <= shd_dp;
      end
      pending  <= pending_nxt_c;
      wr_ready <= ~pending_nxt_c;
    end
  end

  // Registered display outputs and frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      seg        <= {7{SEG_ACTIVE_LOW}};
      dp         <= SEG_ACTIVE_LOW;
      frame_done <= 1'b0;
    end else begin
      an         <= an_c;
      seg        <= seg_c;
      dp         <= dp_c;
      frame_done <= wrap_c;
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl: 4 digits, 10-cycle slots, 2 blank cycles.
module tb_led_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int tests_run;
  int tests_failed;
  int n;

  led_scan_ctrl #(
    .NUM_DIGITS    (4),
    .SLOT_CYCLES   (10),
    .BLANK_CYCLES  (2),
    .AN_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_dp     (wr_dp),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance k clock edges, landing 1 time unit after the last one.
  task automatic tick(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Step until frame_done is seen; returns edges waited.
  task automatic wait_frame(input string tag, output int cnt);
    logic found;
    found = 1'b0;
    cnt   = 0;
    while (!found && cnt < 200) begin
      tick(1);
      cnt++;
      if (frame_done === 1'b1) found = 1'b1;
    end
    chk(tag, 16'(found), 16'h1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst      = 1'b1;
    enable   = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 16'h0;
    wr_dp    = 4'h0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an",    16'(an),         16'hF);
    chk("rst_seg",   16'(seg),        16'h7F);
    chk("rst_dp",    16'(dp),         16'h1);
    chk("rst_fd",    16'(frame_done), 16'h0);
    chk("rst_ready", 16'(wr_ready),   16'h0);
    rst    = 1'b0;
    enable = 1'b1;

    // Test 1: slot timing and digit stepping
    tick(1);
    chk("t1_ready_up", 16'(wr_ready), 16'h1);
    chk("t1_idle_dark", 16'(an), 16'hF);
    tick(2);
    chk("t1_blank_an", 16'(an), 16'hF);
    tick(1);
    chk("t1_d0_an",  16'(an),  16'hE);
    chk("t1_d0_seg", 16'(seg), 16'h40);
    chk("t1_d0_dp",  16'(dp),  16'h1);
    tick(7);
    chk("t1_d0_last_an", 16'(an), 16'hE);
    tick(1);
    chk("t1_d1_blank_an", 16'(an), 16'hF);
    tick(1);
    chk("t1_d1_blank2_an", 16'(an), 16'hF);
    tick(1);
    chk("t1_d1_an", 16'(an), 16'hD);

    // Test 2: write mid-frame, visible only after frame wrap
    wr_valid = 1'b1;
    wr_data  = 16'h8F10;
    wr_dp    = 4'b0000;
    tick(1);
    wr_valid = 1'b0;
    chk("t2_ready_drop", 16'(wr_ready), 16'h0);
    chk("t2_mid_d1_seg", 16'(seg), 16'h40);
    tick(10);
    chk("t2_mid_d2_an",  16'(an),  16'hB);
    chk("t2_mid_d2_seg", 16'(seg), 16'h40);
    wait_frame("t2_frame_timeout", n);
    chk("t1_frame_period", 16'(n), 16'd16);
    chk("t2_ready_after_commit", 16'(wr_ready), 16'h1);
    tick(1);
    chk("t2_fd_one_cycle", 16'(frame_done), 16'h0);
    tick(12);
    chk("t2_d1_an",  16'(an),  16'hD);
    chk("t2_d1_seg", 16'(seg), 16'h79);
    tick(10);
    chk("t2_d2_an",  16'(an),  16'hB);
    chk("t2_d2_seg", 16'(seg), 16'h0E);
    tick(10);
    chk("t2_d3_an",  16'(an),  16'h7);
    chk("t2_d3_seg", 16'(seg), 16'h00);
    chk("t2_d3_dp",  16'(dp),  16'h1);

    // Test 3: back-to-back writes with wr_valid held
    wr_valid = 1'b1;
    wr_data  = 16'h1234;
    wr_dp    = 4'b0001;
    tick(1);
    chk("t3_first_accept", 16'(wr_ready), 16'h0);
    wr_data = 16'hABCD;
    wr_dp   = 4'b1000;
    tick(5);
    chk("t3_ready_low_pre_wrap", 16'(wr_ready),   16'h0);
    chk("t3_fd_low_pre_wrap",    16'(frame_done), 16'h0);
    tick(1);
    chk("t3_ready_after_commit", 16'(wr_ready),   16'h1);
    chk("t3_fd_pulse",           16'(frame_done), 16'h1);
    tick(1);
    chk("t3_second_accept", 16'(wr_ready), 16'h0);
    wr_valid = 1'b0;
    tick(2);
    chk("t3_w1_d0_seg", 16'(seg), 16'h19);
    chk("t3_w1_d0_dp",  16'(dp),  16'h0);
    tick(30);
    chk("t3_w1_d3_seg", 16'(seg), 16'h79);
    chk("t3_w1_d3_dp",  16'(dp),  16'h1);
    wait_frame("t3_frame_timeout", n);
    chk("t3_frame_wait", 16'(n), 16'd7);
    chk("t3_ready_second_commit", 16'(wr_ready), 16'h1);
    tick(3);
    chk("t3_w2_d0_seg", 16'(seg), 16'h21);
    chk("t3_w2_d0_dp",  16'(dp),  16'h1);
    tick(30);
    chk("t3_w2_d3_seg", 16'(seg), 16'h08);
    chk("t3_w2_d3_dp",  16'(dp),  16'h0);

    // Test 4: accept on the frame-wrap cycle, shown one frame later
    tick(6);
    wr_valid = 1'b1;
    wr_data  = 16'h5555;
    wr_dp    = 4'b0000;
    tick(1);
    wr_valid = 1'b0;
    chk("t4_fd_pulse", 16'(frame_done), 16'h1);
    chk("t4_accepted", 16'(wr_ready),   16'h0);
    tick(3);
    chk("t4_old_d0_seg", 16'(seg), 16'h21);
    tick(10);
    chk("t4_old_d1_an",  16'(an),  16'hD);
    chk("t4_old_d1_seg", 16'(seg), 16'h46);
    wait_frame("t4_frame_timeout", n);
    chk("t4_ready_commit", 16'(wr_ready), 16'h1);
    tick(3);
    chk("t4_new_d0_an",  16'(an),  16'hE);
    chk("t4_new_d0_seg", 16'(seg), 16'h12);

    // Test 5: disable mid-DRIVE, write while idle, re-enable
    enable = 1'b0;
    tick(1);
    chk("t5_an_lag", 16'(an), 16'hE);
    tick(1);
    chk("t5_an_dark",  16'(an),  16'hF);
    chk("t5_seg_dark", 16'(seg), 16'h7F);
    wr_valid = 1'b1;
    wr_data  = 16'h00C7;
    wr_dp    = 4'b0010;
    tick(1);
    wr_valid = 1'b0;
    chk("t5_idle_accept", 16'(wr_ready), 16'h0);
    tick(1);
    chk("t5_idle_commit", 16'(wr_ready), 16'h1);
    enable = 1'b1;
    tick(3);
    chk("t5_reen_blank_an", 16'(an), 16'hF);
    tick(1);
    chk("t5_reen_d0_an",  16'(an),  16'hE);
    chk("t5_reen_d0_seg", 16'(seg), 16'h78);
    chk("t5_reen_d0_dp",  16'(dp),  16'h1);
    tick(10);
    chk("t5_reen_d1_an",  16'(an),  16'hD);
    chk("t5_reen_d1_seg", 16'(seg), 16'h46);
    chk("t5_reen_d1_dp",  16'(dp),  16'h0);

    // Test 6: asynchronous reset mid-slot on digit 2
    tick(10);
    chk("t6_pre_d2_an",  16'(an),  16'hB);
    chk("t6_pre_d2_seg", 16'(seg), 16'h40);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_an",    16'(an),         16'hF);
    chk("t6_async_seg",   16'(seg),        16'h7F);
    chk("t6_async_dp",    16'(dp),         16'h1);
    chk("t6_async_ready", 16'(wr_ready),   16'h0);
    chk("t6_async_fd",    16'(frame_done), 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
    chk("t6_ready_up", 16'(wr_ready), 16'h1);
    chk("t6_dark",     16'(an),       16'hF);
    tick(3);
    chk("t6_d0_an",  16'(an),  16'hE);
    chk("t6_d0_seg", 16'(seg), 16'h40);
    tick(10);
    chk("t6_d1_an",  16'(an),  16'hD);
    chk("t6_d1_seg", 16'(seg), 16'h40);
    chk("t6_d1_dp",  16'(dp),  16'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
